obj_spawn_scheduler: RTL
========================

# obj_spawn_scheduler

Schedules new on-screen objects into the five game-object slots. Once per VGA frame it arbitrates between MIDI-driven spawn requests and RNG-driven spawn requests, enforces a minimum frame gap between spawns, finds a free slot round-robin, and issues a single packed object word for game logic to load. It sits between the MIDI/RNG front end and the object registers in game logic.

## Interface
- SCREEN_WIDTH, 1024, horizontal spawn position placed in word bits 20:10
- Y_BASE, 220, offset added to the requested vertical offset
- MIN_GAP, 8, frame ticks suppressed after each spawn (4-bit range, 0..15)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (vsync pulse)
- slot_busy  in  5  bit i set when object slot i+1 is nonzero
- midi_req  in  1  one-cycle spawn request from the MIDI path
- midi_id  in  2  identity for a MIDI spawn
- midi_y  in  8  vertical offset for a MIDI spawn
- rng_req  in  1  level; RNG wants a spawn this frame
- rng_id  in  2  identity for an RNG spawn
- rng_y  in  8  vertical offset for an RNG spawn
- spawn_valid  out  1  one-cycle strobe; load spawn_word into slot spawn_slot
- spawn_slot  out  3  target slot index, 0..4
- spawn_word  out  26  {3'b000, id[1:0], SCREEN_WIDTH[10:0], Y_BASE+y (10 bits)}
- midi_ack  out  1  one-cycle pulse with spawn_valid when MIDI won
- rng_ack  out  1  one-cycle pulse with spawn_valid when RNG won
- active_count  out  3  registered popcount of slot_busy
- drop_count  out  8  saturating count of lost requests

## Operation
- MIDI hold register: 1-deep (valid, id, y). midi_req loads it in any state.
  - If the hold is already valid and is not being consumed that cycle, the old entry is overwritten and drop_count increments.
  - If midi_req coincides with the ISSUE cycle that consumes the hold, the new request is kept and no drop is counted.
- cooldown: 4-bit register.
  - A frame_tick in IDLE with cooldown≠0 decrements it and starts no arbitration.
  - Loaded with MIN_GAP in ISSUE.
  - Consecutive spawns are therefore at least MIN_GAP+1 ticks apart.
- FSM states: IDLE, ARB, SCAN, ISSUE.
  - IDLE → ARB: on frame_tick with cooldown=0 and (hold valid or rng_req). A frame_tick with no request does nothing.
  - ARB: selects the winner, MIDI hold over RNG. Latches winner id/y and a source flag; RNG id/y are sampled here. Sets scan index to rr_ptr. → SCAN.
  - SCAN: tests slot_busy[idx], one slot per cycle.
    - Slot free → ISSUE.
    - Slot busy → idx=(idx+1) mod 5.
    - After 5 busy slots → IDLE, no spawn. A MIDI winner stays in the hold. An RNG winner is discarded and drop_count increments.
  - ISSUE: asserts spawn_valid, spawn_slot=idx, the matching ack, and spawn_word.
    - Sets rr_ptr=(idx+1) mod 5, clears the hold if MIDI won, loads cooldown. → IDLE.
- A frame_tick arriving outside IDLE is ignored and does not decrement cooldown.
- An RNG request that loses to MIDI is neither served nor counted as dropped.
- Vertical arithmetic: Y_BASE + zero-extended y, truncated to 10 bits.
- drop_count saturates at 255.
- Reset (asynchronous, any state): state=IDLE, hold cleared, cooldown=0, rr_ptr=0. All outputs 0: spawn_valid, spawn_slot, spawn_word, midi_ack, rng_ack, active_count, drop_count.

## Timing
- frame_tick sampled at cycle T; ARB at T+1; first SCAN at T+2. With k busy slots skipped, ISSUE/spawn_valid is at T+3+k, k=0..4.
- All-busy abort: back in IDLE at T+7.
- spawn_valid, acks, slot and word are registered outputs valid only during the ISSUE cycle. spawn_word/spawn_slot hold their last value otherwise.
- slot_busy is used combinationally in SCAN.
  - Game logic reflects a loaded slot by the next frame.
  - No in-flight hazard, since the next scan is at least one frame later.
- active_count lags slot_busy by one cycle.

## Test plan
- Reset, then rng_req=1, rng_id=1, rng_y=10, slot_busy=0, one frame_tick → spawn_valid at T+3. Expect spawn_slot=0, spawn_word={000,01,10000000000,0011100110}, rng_ack=1, midi_ack=0.
- midi_req (id=2, y=0) and rng_req in the same frame, slot_busy=5'b00011, rr_ptr=1:
  - spawn_slot=2 at T+4, midi_ack=1, word y=220.
  - RNG is not dropped; drop_count stays 0.
- MIN_GAP=2 with continuous rng_req and free slots: spawns on ticks 0, 3, 6. Slots rotate 0, 1, 2.
- slot_busy=5'b11111 at the tick with an RNG winner → no spawn_valid, IDLE at T+7, drop_count=1. Repeat with a MIDI winner → hold stays valid; it is served on the first later tick with a free slot.
- Two midi_req pulses before a tick → drop_count=1; the second request's id/y are spawned.
- Assert reset during SCAN, then release → no spawn_valid, all outputs 0, cooldown 0. A request on the next tick spawns into slot 0.

Source files
------------

// File: rtl/obj_spawn_scheduler.sv
// obj_spawn_scheduler
//   Once per frame, picks a spawn request (a held MIDI request beats an RNG
//   request). It enforces a cooldown of frame ticks after each spawn, then
//   searches the five object slots round-robin for a free one. On success it
//   issues a one-cycle strobe with the packed object word for game logic.
// Ports:
//   clock_i, reset_i           clock, asynchronous active-high reset
//   frame_tick_i               one pulse per frame
//   slot_busy_i[4:0]           bit i set when object slot i is occupied
//   midi_req_i/id_i/y_i        one-cycle MIDI spawn request
//   rng_req_i/id_i/y_i         level RNG spawn request
//   spawn_valid_o              one-cycle load strobe
//   spawn_slot_o, spawn_word_o target slot and packed object word (held)
//   midi_ack_o, rng_ack_o      which source was served
//   active_count_o             registered popcount of slot_busy_i
//   drop_count_o               saturating count of lost requests
module obj_spawn_scheduler #(
  parameter int SCREEN_WIDTH = 1024,
  parameter int Y_BASE       = 220,
  parameter int MIN_GAP      = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        frame_tick_i,
  input  logic [4:0]  slot_busy_i,
  input  logic        midi_req_i,
  input  logic [1:0]  midi_id_i,
  input  logic [7:0]  midi_y_i,
  input  logic        rng_req_i,
  input  logic [1:0]  rng_id_i,
  input  logic [7:0]  rng_y_i,
  output logic        spawn_valid_o,
  output logic [2:0]  spawn_slot_o,
  output logic [25:0] spawn_word_o,
  output logic        midi_ack_o,
  output logic        rng_ack_o,
  output logic [2:0]  active_count_o,
  output logic [7:0]  drop_count_o
);

  localparam logic [10:0] SW_FIELD = 11'(SCREEN_WIDTH);
  localparam logic [9:0]  YB_FIELD = 10'(Y_BASE);
  localparam logic [3:0]  GAP      = 4'(MIN_GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_SCAN  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  state_t      state_q;
  logic        hold_valid_q;
  logic [1:0]  hold_id_q;
  logic [7:0]  hold_y_q;
  logic [3:0]  cooldown_q;
  logic [2:0]  rr_ptr_q;
  logic [2:0]  idx_q;
  logic [2:0]  scan_cnt_q;
  logic        win_midi_q;
  logic [1:0]  win_id_q;
  logic [7:0]  win_y_q;
  logic        spawn_valid_q;
  logic [2:0]  spawn_slot_q;
  logic [25:0] spawn_word_q;
  logic        midi_ack_q;
  logic        rng_ack_q;
  logic [2:0]  active_count_q;
  logic [7:0]  drop_count_q;

  logic [2:0]  idx_inc_s;
  logic        hold_consume_s;
  logic        midi_drop_s;
  logic        rng_drop_s;
  logic [1:0]  drop_inc_s;
  logic [8:0]  drop_sum_s;
  logic [7:0]  drop_count_d;
  logic [2:0]  active_count_d;
  logic [9:0]  word_y_s;

  // Next-slot index, drop accounting and slot popcount.
  always_comb begin
    idx_inc_s      = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    hold_consume_s = (state_q == S_ISSUE) && win_midi_q;
    // A new MIDI request only displaces an entry that is not leaving this cycle.
    midi_drop_s    = midi_req_i && hold_valid_q && !hold_consume_s;
    rng_drop_s     = (state_q == S_SCAN) && slot_busy_i[idx_q] &&
                     (scan_cnt_q == 3'd4) && !win_midi_q;
    drop_inc_s     = {1'b0, midi_drop_s} + {1'b0, rng_drop_s};
    drop_sum_s     = {1'b0, drop_count_q} + {7'd0, drop_inc_s};
    if (drop_sum_s > 9'd255) begin
      drop_count_d = 8'hFF;
    end else begin
      drop_count_d = drop_sum_s[7:0];
    end
    active_count_d = 3'd0;
    for (int i = 0; i < 5; i++) begin
      active_count_d = active_count_d + {2'b00, slot_busy_i[i]};
    end
    word_y_s = YB_FIELD + {2'b00, win_y_q};
  end

  // MIDI hold register, counters and the spawn FSM with its registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      hold_valid_q   <= 1'b0;
      hold_id_q      <= 2'd0;
      hold_y_q       <= 8'd0;
      cooldown_q     <= 4'd0;
      rr_ptr_q       <= 3'd0;
      idx_q          <= 3'd0;
      scan_cnt_q     <= 3'd0;
      win_midi_q     <= 1'b0;
      win_id_q       <= 2'd0;
      win_y_q        <= 8'd0;
      spawn_valid_q  <= 1'b0;
      spawn_slot_q   <= 3'd0;
      spawn_word_q   <= 26'd0;
      midi_ack_q     <= 1'b0;
      rng_ack_q      <= 1'b0;
      active_count_q <= 3'd0;
      drop_count_q   <= 8'd0;
    end else begin
      active_count_q <= active_count_d;
      drop_count_q   <= drop_count_d;
      spawn_valid_q  <= 1'b0;
      midi_ack_q     <= 1'b0;
      rng_ack_q      <= 1'b0;

      // A request arriving in the consuming cycle wins over the clear.
      if (midi_req_i) begin
        hold_valid_q <= 1'b1;
        hold_id_q    <= midi_id_i;
        hold_y_q     <= midi_y_i;
      end else if (hold_consume_s) begin
        hold_valid_q <= 1'b0;
      end else begin
        hold_valid_q <= hold_valid_q;
      end

      case (state_q)
        S_IDLE: begin
          if (frame_tick_i) begin
            if (cooldown_q != 4'd0) begin
              cooldown_q <= cooldown_q - 4'd1;
            end else if (hold_valid_q || rng_req_i) begin
              state_q <= S_ARB;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ARB: begin
          if (hold_valid_q) begin
            win_midi_q <= 1'b1;
            win_id_q   <= hold_id_q;
            win_y_q    <= hold_y_q;
          end else begin
            win_midi_q <= 1'b0;
            win_id_q   <= rng_id_i;
            win_y_q    <= rng_y_i;
          end
          idx_q      <= rr_ptr_q;
          scan_cnt_q <= 3'd0;
          state_q    <= S_SCAN;
        end
        S_SCAN: begin
          if (!slot_busy_i[idx_q]) begin
            spawn_valid_q <= 1'b1;
            spawn_slot_q  <= idx_q;
            spawn_word_q  <= {3'b000, win_id_q, SW_FIELD, word_y_s};
            midi_ack_q    <= win_midi_q;
            rng_ack_q     <= !win_midi_q;
            state_q       <= S_ISSUE;
          end else if (scan_cnt_q == 3'd4) begin
            // Every slot busy: a MIDI winner simply stays held for a later frame.
            state_q <= S_IDLE;
          end else begin
            idx_q      <= idx_inc_s;
            scan_cnt_q <= scan_cnt_q + 3'd1;
            state_q    <= S_SCAN;
          end
        end
        S_ISSUE: begin
          rr_ptr_q   <= idx_inc_s;
          cooldown_q <= GAP;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign spawn_valid_o  = spawn_valid_q;
  assign spawn_slot_o   = spawn_slot_q;
  assign spawn_word_o   = spawn_word_q;
  assign midi_ack_o     = midi_ack_q;
  assign rng_ack_o      = rng_ack_q;
  assign active_count_o = active_count_q;
  assign drop_count_o   = drop_count_q;

endmodule
